// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receiver for start + 8 data (LSB first) + parity + stop.
// Each bit is sampled once at mid-bit. The received byte and its status are
// held for the host, which consumes them with a READ strobe.
module uart_rx_frame #(
  parameter int unsigned BIT_TIME   = 5208,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RX,
  input  logic       READ,
  output logic [7:0] DATA,
  output logic       RXRDY,
  output logic       PERR,
  output logic       FERR,
  output logic       OVF
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam logic [CNT_W-1:0] T_HALF = CNT_W'(BIT_TIME / 2 - 1);
  localparam logic [CNT_W-1:0] T_FULL = CNT_W'(BIT_TIME - 1);
  localparam logic             ODD    = (PARITY_ODD != 0);

  state_t           state, state_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic [2:0]       bitcnt, bitcnt_n;
  logic [7:0]       shreg, shreg_n;
  logic             par, par_n;
  logic [7:0]       data_n;
  logic             rdy_n, perr_n, ferr_n, ovf_n;

  logic rx_m, rx_s, rx_d;

  // Two-flop synchronizer for the asynchronous RX line, plus one history flop for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // FSM, bit timer, shift register and host-visible status registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      timer  <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      par    <= 1'b0;
      DATA   <= '0;
      RXRDY  <= 1'b0;
      PERR   <= 1'b0;
      FERR   <= 1'b0;
      OVF    <= 1'b0;
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      bitcnt <= bitcnt_n;
      shreg  <= shreg_n;
      par    <= par_n;
      DATA   <= data_n;
      RXRDY  <= rdy_n;
      PERR   <= perr_n;
      FERR   <= ferr_n;
      OVF    <= ovf_n;
    end
  end

  // Next-state logic: host handshake first, so a frame completing on the same
  // edge as READ overrides the RXRDY clear and suppresses the overrun flag
  always_comb begin
    state_n  = state;
    timer_n  = timer + 1'b1;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    par_n    = par;
    data_n   = DATA;
    rdy_n    = RXRDY;
    perr_n   = PERR;
    ferr_n   = FERR;
    ovf_n    = OVF;

    if (READ && RXRDY) begin
      rdy_n = 1'b0;
      ovf_n = 1'b0;
    end

    unique case (state)
      ST_IDLE: begin
        timer_n = '0;
        if (!rx_s && rx_d) begin
          state_n = ST_START;
        end
      end

      ST_START: begin
        if (timer == T_HALF) begin
          timer_n = '0;
          if (!rx_s) begin
            state_n  = ST_DATA;
            bitcnt_n = '0;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end

      ST_DATA: begin
        if (timer == T_FULL) begin
          timer_n  = '0;
          shreg_n  = {rx_s, shreg[7:1]};
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
            state_n = ST_PARITY;
          end
        end
      end

      ST_PARITY: begin
        if (timer == T_FULL) begin
          timer_n = '0;
          par_n   = rx_s;
          state_n = ST_STOP;
        end
      end

      ST_STOP: begin
        if (timer == T_FULL) begin
          timer_n = '0;
          data_n  = shreg;
          perr_n  = ((^shreg) ^ par) != ODD;
          ferr_n  = ~rx_s;
          rdy_n   = 1'b1;
          if (RXRDY && !READ) begin
            ovf_n = 1'b1;
          end
          state_n = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
        timer_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed bench for uart_rx_frame with BIT_TIME=16.
// Frames are driven bit-serially; expected byte/status entries are queued as
// each frame is sent and popped when the frame's result is checked.
module tb_uart_rx_frame;

  localparam int BT     = 16;
  localparam int FRAME  = 11 * BT;
  localparam int DONE_C = 3 + BT / 2 + 10 * BT;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       RX    = 1'b1;
  logic       READ  = 1'b0;
  logic [7:0] DATA;
  logic       RXRDY, PERR, FERR, OVF;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic mdl_rdy = 1'b0;
  logic mdl_ovf = 1'b0;
  int   lat;

  uart_rx_frame #(
    .BIT_TIME  (BT),
    .CNT_W     (16),
    .PARITY_ODD(0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .RX   (RX),
    .READ (READ),
    .DATA (DATA),
    .RXRDY(RXRDY),
    .PERR (PERR),
    .FERR (FERR),
    .OVF  (OVF)
  );

  always #5 clk = ~clk;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drives one full frame; read_c raises READ for that cycle, abort_c pulls reset low and stops
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stp,
                            input int read_c, input int abort_c);
    logic [10:0] fr;
    exp_t        e;
    bit          aborted;
    fr      = {stp, p, d, 1'b0};
    aborted = 1'b0;
    lat     = -1;
    if (abort_c < 0) begin
      e.d  = d;
      e.pe = (^d) ^ p;
      e.fe = ~stp;
      sb.push_back(e);
    end
    for (int c = 0; c < FRAME; c++) begin
      @(posedge clk);
      #1;
      if (c == abort_c) begin
        reset   = 1'b0;
        aborted = 1'b1;
        break;
      end
      RX   = fr[c / BT];
      READ = (c == read_c);
      @(negedge clk);
      if (lat < 0 && RXRDY === 1'b1) lat = c;
    end
    READ = 1'b0;
    if (!aborted) begin
      if (read_c == DONE_C - 1) mdl_ovf = 1'b0;
      else if (mdl_rdy) mdl_ovf = 1'b1;
      mdl_rdy = 1'b1;
    end
  endtask

  task automatic check_frame(input string tag);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk8({tag, "_data"}, DATA, e.d);
      chk1({tag, "_perr"}, PERR, e.pe);
      chk1({tag, "_ferr"}, FERR, e.fe);
      chk1({tag, "_rxrdy"}, RXRDY, mdl_rdy);
      chk1({tag, "_ovf"}, OVF, mdl_ovf);
    end
  endtask

  task automatic do_read();
    @(posedge clk);
    #1 READ = 1'b1;
    @(posedge clk);
    #1 READ = 1'b0;
    if (mdl_rdy) begin
      mdl_rdy = 1'b0;
      mdl_ovf = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;

    // Reset held with RX toggling
    #2 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 RX = ~RX;
    end
    @(negedge clk);
    chk8("rst_data", DATA, 8'h00);
    chk1("rst_rxrdy", RXRDY, 1'b0);
    chk1("rst_perr", PERR, 1'b0);
    chk1("rst_ferr", FERR, 1'b0);
    chk1("rst_ovf", OVF, 1'b0);
    #1 RX = 1'b1;
    idle(2);
    reset = 1'b1;

    // Idle line must not produce a byte
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (RXRDY !== 1'b0) seen = 1'b1;
    end
    chk1("idle_no_rdy", seen, 1'b0);

    // Good frame, latency, then READ
    send_frame(8'h07, 1'b1, 1'b1, -1, -1);
    chk1("lat_0x07", (lat >= DONE_C - 1 && lat <= DONE_C + 1), 1'b1);
    check_frame("f07");
    do_read();
    @(negedge clk);
    chk1("read_clr_rdy", RXRDY, 1'b0);
    chk8("read_hold_data", DATA, 8'h07);
    idle(5);

    // Parity error, then framing error
    send_frame(8'hA3, 1'b1, 1'b1, -1, -1);
    check_frame("fA3_perr");
    do_read();
    send_frame(8'h55, 1'b0, 1'b0, -1, -1);
    check_frame("f55_ferr");
    RX = 1'b1;
    idle(20);
    do_read();

    // Short glitch is a false start
    RX = 1'b0;
    idle(4);
    RX = 1'b1;
    idle(20);
    @(negedge clk);
    chk1("glitch_no_rdy", RXRDY, 1'b0);
    chk8("glitch_data", DATA, 8'h55);
    send_frame(8'h3C, 1'b0, 1'b1, -1, -1);
    check_frame("f3C");
    do_read();
    idle(5);

    // Back-to-back frames without READ -> overrun
    send_frame(8'h11, 1'b0, 1'b1, -1, -1);
    check_frame("b2b_first");
    send_frame(8'h22, 1'b0, 1'b1, -1, -1);
    check_frame("b2b_ovf");
    do_read();
    @(negedge clk);
    chk1("ovf_read_rdy", RXRDY, 1'b0);
    chk1("ovf_read_ovf", OVF, 1'b0);
    idle(5);

    // READ on the completion edge of the second frame
    send_frame(8'h11, 1'b0, 1'b1, -1, -1);
    check_frame("b2b2_first");
    send_frame(8'h22, 1'b0, 1'b1, DONE_C - 1, -1);
    check_frame("b2b2_read_edge");
    do_read();
    idle(5);

    // Reset during the 4th data bit, then a clean frame
    send_frame(8'hF0, 1'b0, 1'b1, -1, 4 * BT + BT / 2);
    RX = 1'b1;
    idle(3);
    reset   = 1'b1;
    mdl_rdy = 1'b0;
    mdl_ovf = 1'b0;
    idle(20);
    @(negedge clk);
    chk1("abort_no_rdy", RXRDY, 1'b0);
    chk8("abort_data", DATA, 8'h00);
    send_frame(8'h9E, 1'b1, 1'b1, -1, -1);
    check_frame("f9E");

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_empty observed=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Serial receive path for the board UART; the counterpart of the 11-bit transmit shifter.
- Accepts frames of start(0), 8 data bits LSB-first, parity, stop(1) on the RX line.
- Samples each bit at mid-bit, checks parity and framing, and presents the byte plus status to the host logic with a ready/read handshake.

Parameters:
- BIT_TIME, 5208, clock cycles per bit (100 MHz / 19200 baud); must be even and ≥ 8.
- CNT_W, 16, bit-timer width; 2^CNT_W must exceed BIT_TIME.
- PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low (asserted when 0); clears all state.
- RX  in  1  asynchronous serial input; idles high.
- READ  in  1  one-cycle host strobe; consumes the held byte.
- DATA  out  8  last received byte.
- RXRDY  out  1  byte available in DATA.
- PERR  out  1  parity error on the frame in DATA.
- FERR  out  1  framing error (stop bit sampled 0) on the frame in DATA.
- OVF  out  1  overrun: a frame completed while RXRDY was already set.

Behaviour:
- Reset (reset=0, async): state IDLE, timer 0, bit count 0, shift reg 0.
  - DATA=8'h00; RXRDY, PERR, FERR and OVF all 0; sync flops = 1.
  - Reset mid-frame abandons the frame with no output update.
- RX passes through 2 synchronizer flops (rx_s) plus 1 history flop (rx_d).
- IDLE: start detected when rx_s=0 and rx_d=1 (falling edge). Enter START with timer=0.
- START: timer counts to BIT_TIME/2-1.
  - At terminal, rx_s=0: enter DATA, timer=0, bitcnt=0.
  - At terminal, rx_s=1: false start (glitch); return to IDLE with no flag change.
- DATA: at each timer terminal (BIT_TIME-1), shift rx_s into bit 7 of the shift reg (shift right) and increment bitcnt.
  - After the 8th sample, enter PARITY.
- PARITY: at terminal, capture p = rx_s; enter STOP.
- STOP: at terminal, on the same clock edge:
  - DATA <= shift reg.
  - PERR <= (^shift reg ^ p) != PARITY_ODD.
  - FERR <= ~rx_s.
  - RXRDY <= 1.
  - OVF set if RXRDY was 1 and READ=0 on this edge.
  - Return to IDLE.
- After FERR (line held low / break), IDLE requires rx_d=1 before a new falling edge counts. This is inherent in edge detection.
- Timer resets to 0 on every state transition. One sample per bit; no majority voting.
- Latency: falling edge on RX to RXRDY=1 is 2 + BIT_TIME/2 + 10*BIT_TIME cycles (±1 for synchronizer phase).
- Handshake:
  - READ with RXRDY=1 clears RXRDY and OVF on the next edge. PERR, FERR and DATA hold until the next frame completes.
  - READ with RXRDY=0 has no effect.
  - READ on the same edge as frame completion: completion wins, so RXRDY stays 1 and DATA updates. OVF is not set, because the old byte counts as consumed.
- Overrun: DATA and PERR/FERR are overwritten with the newest frame. OVF is sticky until READ.
- Back-to-back frames: the stop-bit sample occurs mid-stop, so the next start edge is caught with no dead time.

Test Plan (sim with BIT_TIME=16):
- Reset held low, RX toggling → all outputs 0; release reset, RX idle high for 100 cycles → RXRDY stays 0.
- Frame 0x07, even parity bit 1, stop 1 → RXRDY=1 about 170 cycles after the start edge; DATA=8'h07, PERR=0, FERR=0.
  - Then a READ pulse → RXRDY=0 next cycle; DATA still 8'h07.
- Frame 0xA3 with parity bit 1 (wrong, PARITY_ODD=0) → DATA=8'hA3, PERR=1. Frame 0x55 with stop bit 0 → FERR=1, RXRDY=1.
- RX low for 4 cycles then high → no RXRDY, state back to IDLE; a valid 0x3C frame 20 cycles later → DATA=8'h3C.
- Two back-to-back frames 0x11 then 0x22 with no READ → DATA=8'h22, RXRDY=1, OVF=1.
  - READ → RXRDY=0, OVF=0.
  - Repeat with READ on the exact completion edge of frame 2 → OVF=0, RXRDY=1.
- Drive reset low at the 4th data bit of a frame, release, then send 0x9E → DATA=8'h9E, no errors, no spurious RXRDY from the aborted frame.
